// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the ALU write-back
//   path and the LSU return path. Each requester uses a valid/ready handshake.
//   At most one requester is granted per cycle, with round-robin priority.
//   The accepted write is registered onto WE3/AD3/WD3 one cycle later.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall                     blocks all grants this cycle
//   alu_valid/rd/wd, alu_ready  ALU write-back request and acceptance
//   lsu_valid/rd/wd, lsu_ready  LSU write-back request and acceptance
//   WE3, AD3, WD3             registered register-file write port
//   pref_lsu                  round-robin preference (1 = LSU preferred)
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_GUARD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_wd,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_wd,
  output logic                  lsu_ready,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic                  pref_lsu
);

  localparam logic [0:0] PREF_ALU = 1'b0;
  localparam logic [0:0] PREF_LSU = 1'b1;

  logic [0:0]            state;
  logic                  grant_alu;
  logic                  grant_lsu;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_wd;
  logic                  issue;

  // A lone requester always wins; on contention the preferred one wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && !stall) begin
      grant_alu = alu_valid && (!lsu_valid || (state == PREF_ALU));
      grant_lsu = lsu_valid && (!alu_valid || (state == PREF_LSU));
    end
  end

  always_comb begin
    sel_rd = grant_lsu ? lsu_rd : alu_rd;
    sel_wd = grant_lsu ? lsu_wd : alu_wd;
    // Writes to r0 are still accepted (and rotate preference) but never issued.
    issue  = (grant_alu || grant_lsu) &&
             !((ZERO_GUARD != 0) && (sel_rd == '0));
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;
  assign pref_lsu  = (state == PREF_LSU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PREF_ALU;
    end else if (grant_alu) begin
      state <= PREF_LSU;
    end else if (grant_lsu) begin
      state <= PREF_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= issue;
      if (grant_alu || grant_lsu) begin
        AD3 <= sel_rd;
        WD3 <= sel_wd;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter: handshake, round-robin order,
//   same-rd ordering, r0 guard, stall and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic        lsu_ready;
  logic        WE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;
  logic        pref_lsu;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] rf [32];

  regfile_wb_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .ZERO_GUARD (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_wd    (lsu_wd),
    .lsu_ready (lsu_ready),
    .WE3       (WE3),
    .AD3       (AD3),
    .WD3       (WD3),
    .pref_lsu  (pref_lsu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file model written by the arbiter's write port.
  always @(posedge clk) begin
    if (WE3) rf[AD3] <= WD3;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic exp_alu [4];
  logic [4:0] exp_ad [4];
  int ai;
  int li;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    exp_alu[0] = 1'b1; exp_alu[1] = 1'b0; exp_alu[2] = 1'b1; exp_alu[3] = 1'b0;
    exp_ad[0] = 5'd1;  exp_ad[1] = 5'd9;  exp_ad[2] = 5'd2;  exp_ad[3] = 5'd10;

    // Reset state; a valid request during reset must not be granted.
    rst = 1'b1; stall = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wd = 32'h2;
    #2;
    chk("rst_we3", WE3, 0);
    chk("rst_ad3", AD3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_pref", pref_lsu, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;

    // Single ALU request.
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    #1;
    chk("t1_alu_ready", alu_ready, 1);
    chk("t1_lsu_ready", lsu_ready, 0);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    chk("t1_we3", WE3, 1);
    chk("t1_ad3", AD3, 5);
    chk("t1_wd3", WD3, 32'hDEADBEEF);
    chk("t1_pref", pref_lsu, 1);
    @(posedge clk); #1;
    chk("t1_idle_we3", WE3, 0);
    chk("t1_idle_ad3_hold", AD3, 5);

    // Round-robin from reset with both requesters valid.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ai = 0; li = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_rd = 5'(1 + ai); alu_wd = 32'hA0 + 32'(ai);
      lsu_valid = 1'b1; lsu_rd = 5'(9 + li); lsu_wd = 32'hB0 + 32'(li);
      #1;
      chk("rr_alu_ready", alu_ready, exp_alu[i]);
      chk("rr_lsu_ready", lsu_ready, !exp_alu[i]);
      chk("rr_one_ready", alu_ready & lsu_ready, 0);
      if (exp_alu[i]) ai++; else li++;
      @(posedge clk); #1;
      chk("rr_we3", WE3, 1);
      chk("rr_ad3", AD3, exp_ad[i]);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // Same rd from both; ALU preferred, LSU data must persist.
    @(negedge clk);
    chk("same_pref", pref_lsu, 0);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h22;
    #1;
    chk("same_alu_first", alu_ready, 1);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    chk("same_wd3_first", WD3, 32'h11);
    chk("same_lsu_second", lsu_ready, 1);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk("same_wd3_second", WD3, 32'h22);
    chk("same_ad3_second", AD3, 7);
    @(posedge clk); #1;
    chk("same_rf7", rf[7], 32'h22);

    // r0 guard: accepted, rotates preference, not issued.
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    chk("z_pre_pref", pref_lsu, 1);
    @(negedge clk);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'hFF;
    #1;
    chk("z_lsu_ready", lsu_ready, 1);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk("z_we3", WE3, 0);
    chk("z_pref", pref_lsu, 0);
    @(posedge clk); #1;
    chk("z_rf0", rf[0], 0);

    // Stall with LSU preferred; earlier registered write still shows.
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
    @(posedge clk); #1;
    stall = 1'b1;
    alu_rd = 5'd6; alu_wd = 32'h66;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_wd = 32'h88;
    #1;
    chk("st_prior_we3", WE3, 1);
    chk("st_prior_ad3", AD3, 4);
    for (int i = 0; i < 3; i++) begin
      chk("st_alu_ready", alu_ready, 0);
      chk("st_lsu_ready", lsu_ready, 0);
      @(posedge clk); #1;
      chk("st_we3", WE3, 0);
      chk("st_pref", pref_lsu, 1);
    end
    stall = 1'b0;
    #1;
    chk("st_rel_lsu_ready", lsu_ready, 1);
    chk("st_rel_alu_ready", alu_ready, 0);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    chk("st_rel_ad3", AD3, 8);
    chk("st_rel_pref", pref_lsu, 0);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    chk("st_alu_we3", WE3, 1);
    chk("st_alu_ad3", AD3, 6);

    // Asynchronous reset mid-cycle cancels the pending write.
    #2;
    rst = 1'b1;
    #1;
    chk("ar_we3", WE3, 0);
    chk("ar_ad3", AD3, 0);
    chk("ar_wd3", WD3, 0);
    chk("ar_pref", pref_lsu, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_post_pref", pref_lsu, 0);
    chk("ar_post_we3", WE3, 0);
    chk("ar_rf6_lost", rf[6], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
